// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU issue stage. Decodes the incoming instruction into
// an ALU operation plus two operands and holds the result in a 2-entry
// FIFO (head + skid) so upstream can keep streaming while the ALU stalls.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   inValid / inReady      upstream handshake (inReady low only when FULL)
//   inst, pc               instruction word and its address
//   rs1Data, rs2Data       register-file read values for this instruction
//   flush                  drop everything buffered and incoming
//   outValid / outReady    downstream handshake for the head entry
//   aluOp, aluX, aluY      head entry: operation and operands
//   illegal                head entry failed decode (issued with ADD 0,0)
//
// Build option: define ALU_ISSUE_BRANCH_EN to decode conditional branches
// (opcode 1100011) into compare operations; otherwise they are illegal.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    input  logic        flush,
    output logic        outValid,
    input  logic        outReady,
    output logic [3:0]  aluOp,
    output logic [31:0] aluX,
    output logic [31:0] aluY,
    output logic        illegal
);
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_OR  = 4'h2,
                           OP_XOR = 4'h3, OP_AND = 4'h4, OP_SLTU = 4'h5,
                           OP_SLT = 4'h6, OP_SRL = 4'h7, OP_SRA = 4'h8,
                           OP_SLL = 4'h9, OP_GEU = 4'hB, OP_GE  = 4'hC,
                           OP_EQ  = 4'hD, OP_NE  = 4'hE;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    // ---------------- decode ----------------
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [3:0]  w_op;
    logic [31:0] w_x, w_y;
    logic        w_bad;
    logic [68:0] w_dec;    // {illegal, op, x, y}
    logic        w_unused; // register-index fields are not needed here

    assign w_opc    = inst[6:0];
    assign w_f3     = inst[14:12];
    assign w_f7     = inst[31:25];
    assign w_unused = ^{inst[11:7], inst[19:15]};

    always_comb begin
        w_op  = OP_ADD;
        w_x   = rs1Data;
        w_y   = rs2Data;
        w_bad = 1'b0;
        case (w_opc)
            7'b0110011: begin
                // funct7 0x20 is only meaningful for SUB and SRA
                if (w_f7 == 7'h00 ||
                    (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    case (w_f3)
                        3'b000:  w_op = w_f7[5] ? OP_SUB : OP_ADD;
                        3'b001:  w_op = OP_SLL;
                        3'b010:  w_op = OP_SLT;
                        3'b011:  w_op = OP_SLTU;
                        3'b100:  w_op = OP_XOR;
                        3'b101:  w_op = w_f7[5] ? OP_SRA : OP_SRL;
                        3'b110:  w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end else begin
                    w_bad = 1'b1;
                end
            end
            7'b0010011: begin
                w_y = {{20{inst[31]}}, inst[31:20]};
                case (w_f3)
                    3'b000:  w_op = OP_ADD;
                    3'b001: begin
                        w_op = OP_SLL;
                        w_y  = {27'd0, inst[24:20]};
                    end
                    3'b010:  w_op = OP_SLT;
                    3'b011:  w_op = OP_SLTU;
                    3'b100:  w_op = OP_XOR;
                    3'b101: begin
                        w_op = inst[30] ? OP_SRA : OP_SRL;
                        w_y  = {27'd0, inst[24:20]};
                    end
                    3'b110:  w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
            7'b0110111: begin
                w_x = 32'd0;
                w_y = {inst[31:12], 12'h000};
            end
            7'b0010111: begin
                w_x = pc;
                w_y = {inst[31:12], 12'h000};
            end
`ifdef ALU_ISSUE_BRANCH_EN
            7'b1100011: begin
                case (w_f3)
                    3'b000:  w_op = OP_EQ;
                    3'b001:  w_op = OP_NE;
                    3'b100:  w_op = OP_SLT;
                    3'b101:  w_op = OP_GE;
                    3'b110:  w_op = OP_SLTU;
                    3'b111:  w_op = OP_GEU;
                    default: w_bad = 1'b1;
                endcase
            end
`endif
            default: w_bad = 1'b1;
        endcase
        // Illegal entries travel as a harmless ADD 0,0
        if (w_bad) begin
            w_op = OP_ADD;
            w_x  = 32'd0;
            w_y  = 32'd0;
        end
    end

    assign w_dec = {w_bad, w_op, w_x, w_y};

    // ---------------- FIFO control ----------------
    state_t      r_state, w_next;
    logic [68:0] r_head, r_skid;
    logic        w_acc, w_pop;
    logic        w_ld_head, w_ld_skid, w_shift;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        inReady   = (r_state != S_FULL);
        outValid  = (r_state != S_EMPTY);
        w_acc     = inValid && inReady;
        w_pop     = outValid && outReady;
        w_ld_head = 1'b0;
        w_ld_skid = 1'b0;
        w_shift   = 1'b0;
        if (flush) begin
            w_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_acc) begin
                    w_next    = S_ONE;
                    w_ld_head = 1'b1;
                end
                S_ONE: begin
                    if (w_acc && w_pop) begin
                        w_ld_head = 1'b1;
                    end else if (w_acc) begin
                        w_next    = S_FULL;
                        w_ld_skid = 1'b1;
                    end else if (w_pop) begin
                        w_next = S_EMPTY;
                    end
                end
                default: if (w_pop) begin
                    w_next  = S_ONE;
                    w_shift = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_head)    r_head <= w_dec;
            else if (w_shift) r_head <= r_skid;
            if (w_ld_skid)    r_skid <= w_dec;
        end
    end

    assign illegal = r_head[68];
    assign aluOp   = r_head[67:64];
    assign aluX    = r_head[63:32];
    assign aluY    = r_head[31:0];
endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst, inValid, inReady, flush, outValid, outReady, illegal;
    logic [31:0] inst, pc, rs1Data, rs2Data, aluX, aluY;
    logic [3:0]  aluOp;

    int n_pass = 0;
    int n_total = 0;

    alu_issue dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .inst(inst), .pc(pc), .rs1Data(rs1Data), .rs2Data(rs2Data),
        .flush(flush), .outValid(outValid), .outReady(outReady),
        .aluOp(aluOp), .aluX(aluX), .aluY(aluY), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst, pc, rs1, rs2;
        logic [3:0]  op;
        logic [31:0] x, y;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] x, input logic [31:0] y, input logic ill);
        vec_t v;
        v.name = nm; v.inst = i; v.pc = p; v.rs1 = a; v.rs2 = b;
        v.op = op; v.x = x; v.y = y; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        else n_pass++;
    endtask

    // head entry packed as {illegal, op, x, y}
    function automatic logic [71:0] head();
        return {3'b0, illegal, aluOp, aluX, aluY};
    endfunction

    function automatic logic [71:0] ent(input logic ill, input logic [3:0] op,
                                        input logic [31:0] x, input logic [31:0] y);
        return {3'b0, ill, op, x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        inst = i; pc = p; rs1Data = a; rs2Data = b; inValid = 1'b1;
    endtask

    initial begin
        // decode table
        add("addi_neg", 32'hFFF00093, 0, 32'h10, 0, 4'h0, 32'h10, 32'hFFFFFFFF, 0);
        add("add",      32'h00000033, 0, 32'd9, 32'd4, 4'h0, 32'd9, 32'd4, 0);
        add("sub",      32'h40000033, 0, 32'd10, 32'd3, 4'h1, 32'd10, 32'd3, 0);
        add("or",       32'h00006033, 0, 32'hA, 32'h5, 4'h2, 32'hA, 32'h5, 0);
        add("xor",      32'h00004033, 0, 32'hA, 32'h5, 4'h3, 32'hA, 32'h5, 0);
        add("and",      32'h00007033, 0, 32'hA, 32'h5, 4'h4, 32'hA, 32'h5, 0);
        add("sltu",     32'h00003033, 0, 32'h1, 32'h2, 4'h5, 32'h1, 32'h2, 0);
        add("slt",      32'h00002033, 0, 32'h1, 32'h2, 4'h6, 32'h1, 32'h2, 0);
        add("srl",      32'h00005033, 0, 32'h80, 32'h3, 4'h7, 32'h80, 32'h3, 0);
        add("sra",      32'h40005033, 0, 32'h80, 32'h3, 4'h8, 32'h80, 32'h3, 0);
        add("sll",      32'h00001033, 0, 32'h80, 32'h3, 4'h9, 32'h80, 32'h3, 0);
        add("mul_ill",  32'h02000033, 0, 32'h5, 32'h6, 4'h0, 0, 0, 1);
        add("or_f7ill", 32'h40006033, 0, 32'h5, 32'h6, 4'h0, 0, 0, 1);
        add("srai",     32'h40405093, 0, 32'h55, 32'h99, 4'h8, 32'h55, 32'd4, 0);
        add("slli",     32'h01F09093, 0, 32'h3, 32'h99, 4'h9, 32'h3, 32'd31, 0);
        add("sltiu",    32'h80003093, 0, 32'h7, 32'h99, 4'h5, 32'h7, 32'hFFFFF800, 0);
        add("lui",      32'h12345037, 0, 32'h7, 32'h8, 4'h0, 0, 32'h12345000, 0);
        add("auipc",    32'h00001017, 32'h100, 32'h7, 32'h8, 4'h0, 32'h100, 32'h1000, 0);
        add("zero_ill", 32'h00000000, 0, 32'h7, 32'h8, 4'h0, 0, 0, 1);
        add("load_ill", 32'h00002003, 0, 32'h7, 32'h8, 4'h0, 0, 0, 1);
`ifdef ALU_ISSUE_BRANCH_EN
        add("beq",      32'h00208463, 0, 32'd7, 32'd7, 4'hD, 32'd7, 32'd7, 0);
        add("bge",      32'h00005063, 0, 32'd1, 32'd2, 4'hC, 32'd1, 32'd2, 0);
        add("bltu",     32'h00006063, 0, 32'd1, 32'd2, 4'h5, 32'd1, 32'd2, 0);
        add("br010",    32'h00002063, 0, 32'd1, 32'd2, 4'h0, 0, 0, 1);
`else
        add("beq",      32'h00208463, 0, 32'd7, 32'd7, 4'h0, 0, 0, 1);
        add("bge",      32'h00005063, 0, 32'd1, 32'd2, 4'h0, 0, 0, 1);
`endif

        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inst = 0; pc = 0; rs1Data = 0; rs2Data = 0;
        tick(); tick();
        chk("rst_outValid", outValid, 0);
        chk("rst_inReady",  inReady, 1);
        chk("rst_head",     head(), 0);
        rst = 1'b0;

        // addi x1,x0,5 -> presented the cycle after accept
        drive(32'h00500093, 0, 0, 0);
        outReady = 1'b1;
        tick();
        inValid = 1'b0;
        chk("addi_valid", outValid, 1);
        chk("addi_head",  head(), ent(0, 4'h0, 0, 32'd5));
        tick();
        chk("addi_drain", outValid, 0);

        // streaming: accept and pop together every cycle (ONE->ONE)
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].inst, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
            tick();
            chk({vecs[k].name, "_valid"}, outValid, 1);
            chk(vecs[k].name, head(), ent(vecs[k].ill, vecs[k].op, vecs[k].x, vecs[k].y));
        end
        inValid = 1'b0;
        tick();
        chk("stream_empty", outValid, 0);

        // sra stalled for 3 cycles: head must not move
        outReady = 1'b0;
        drive(32'h40315233, 0, 32'h80000000, 32'd4);
        tick();
        inValid = 1'b0; rs1Data = 32'hDEAD; rs2Data = 32'hBEEF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_valid", outValid, 1);
            chk("stall_head",  head(), ent(0, 4'h8, 32'h80000000, 32'd4));
        end
        outReady = 1'b1;
        tick();
        chk("stall_drain", outValid, 0);

        // fill to FULL, third offer ignored, then drain in order
        outReady = 1'b0;
        drive(32'h00100093, 0, 32'h11, 0);          // A: addi x1,x0,1
        tick();
        drive(32'hABCDE037, 0, 0, 0);               // B: lui
        tick();
        chk("full_inReady", inReady, 0);
        chk("full_headA",   head(), ent(0, 4'h0, 32'h11, 32'd1));
        drive(32'h00004033, 0, 32'h1, 32'h2);       // C: xor, must be refused
        tick();
        chk("full_hold",    inReady, 0);
        chk("full_headA2",  head(), ent(0, 4'h0, 32'h11, 32'd1));
        inValid = 1'b0; outReady = 1'b1;
        tick();
        chk("pop1_inReady", inReady, 1);
        chk("pop1_valid",   outValid, 1);
        chk("pop1_headB",   head(), ent(0, 4'h0, 0, 32'hABCDE000));
        tick();
        chk("pop2_valid",   outValid, 0);
        chk("pop2_inReady", inReady, 1);

        // flush while FULL with a same-cycle offer and pop
        outReady = 1'b0;
        drive(32'h00100093, 0, 1, 0);
        tick(); tick();
        chk("pre_flush_full", inReady, 0);
        flush = 1'b1; outReady = 1'b1;
        drive(32'h00200093, 0, 2, 0);
        tick();
        flush = 1'b0; inValid = 1'b0;
        chk("flush_valid",   outValid, 0);
        chk("flush_inReady", inReady, 1);
        tick();
        chk("flush_stays",   outValid, 0);

        // lui, then reset while ONE (with flush also high)
        outReady = 1'b0;
        drive(32'h12345037, 0, 32'h5, 32'h6);
        tick();
        inValid = 1'b0;
        chk("lui_head", head(), ent(0, 4'h0, 0, 32'h12345000));
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        chk("midrst_valid",   outValid, 0);
        chk("midrst_inReady", inReady, 1);
        chk("midrst_head",    head(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
